packet_stream_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single UART transmit path between several byte-stream packet sources. It grants one source at a time and holds the grant until that source's packet ends, so packets are never interleaved. It sits directly upstream of the packet constructor, which appends the framing sentinel. When enabled, a source-tag byte is prepended to each packet.

---
 rtl/packet_pkg.sv | 17 +
 rtl/packet_stream_arbiter_if.sv | 23 ++
 rtl/round_robin_selector.sv | 33 +++
 rtl/packet_stream_arbiter.sv | 105 ++++++++++
 tb/tb_packet_stream_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_pkg.sv
// Shared definitions for the packet arbitration path: FSM encoding, tag offset, index sizing.
package packet_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TAG    = 2'd1,
        STREAM = 2'd2
    } arb_state_t;

    // Tag byte is grant_id + TAG_OFFSET so it never equals the zero framing sentinel.
    localparam int TAG_OFFSET = 1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/packet_stream_arbiter_if.sv
// Per-source byte streams in, one shared byte stream out to the packet constructor.
interface packet_stream_arbiter_if #(
    parameter int NUM_SOURCES = 4
);
    logic [NUM_SOURCES*8-1:0] in_data;
    logic [NUM_SOURCES-1:0]   in_valid;
    logic [NUM_SOURCES-1:0]   in_last;
    logic [NUM_SOURCES-1:0]   in_ready;
    logic [7:0]               out_data;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/round_robin_selector.sv
// Combinational rotating-priority pick: first set request after i_last_grant, wrapping.
module round_robin_selector
    import packet_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int GW          = idx_width(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] i_req,
    input  logic [GW-1:0]          i_last_grant,
    output logic [GW-1:0]          o_winner,
    output logic                   o_found
);

    int            w_idx;
    logic [GW-1:0] w_sel;

    // Walk from the farthest offset to the nearest so the nearest hit is assigned last.
    always_comb begin
        o_winner = '0;
        o_found  = 1'b0;
        w_idx    = 0;
        w_sel    = '0;
        for (int k = NUM_SOURCES; k >= 1; k--) begin
            w_idx = (int'(i_last_grant) + k) % NUM_SOURCES;
            w_sel = GW'(w_idx);
            if (i_req[w_sel]) begin
                o_winner = w_sel;
                o_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_stream_arbiter.sv
// Packet-level round-robin arbiter onto the UART transmit byte stream; grant held until last beat.
// Optional source-tag byte ahead of each packet when PACKET_STREAM_ARBITER_TAG_EN is defined.
module packet_stream_arbiter
    import packet_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int GW          = idx_width(NUM_SOURCES)
) (
    input  logic                    clock,
    input  logic                    reset,
    packet_stream_arbiter_if.slave  bus,
    output logic [GW-1:0]           grant_id,
    output logic                    busy
);

`ifdef PACKET_STREAM_ARBITER_TAG_EN
    localparam arb_state_t GRANT_NEXT = TAG;
`else
    localparam arb_state_t GRANT_NEXT = STREAM;
`endif

    arb_state_t              r_state;
    logic [GW-1:0]           r_grant_id;
    logic [GW-1:0]           r_last_grant;
    logic [GW-1:0]           w_winner;
    logic                    w_found;
    logic                    w_beat_last;
    logic [NUM_SOURCES-1:0]  w_ready;
    logic [DATA_WIDTH-1:0]   w_src_data [NUM_SOURCES];

    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_unpack
        assign w_src_data[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    round_robin_selector #(
        .NUM_SOURCES (NUM_SOURCES),
        .GW          (GW)
    ) u_sel (
        .i_req        (bus.in_valid),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_found      (w_found)
    );

    assign w_beat_last = bus.in_valid[r_grant_id] & bus.in_last[r_grant_id] & bus.out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= GW'(NUM_SOURCES - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_winner;
                        r_state    <= GRANT_NEXT;
                    end
                end
`ifdef PACKET_STREAM_ARBITER_TAG_EN
                TAG: begin
                    if (bus.out_ready) r_state <= STREAM;
                end
`endif
                STREAM: begin
                    // Remembering the finisher pushes it to lowest priority next round.
                    if (w_beat_last) begin
                        r_last_grant <= r_grant_id;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Data path is a pure pass-through of the granted source; no added latency in STREAM.
    always_comb begin
        bus.out_data  = '0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        w_ready       = '0;
        case (r_state)
`ifdef PACKET_STREAM_ARBITER_TAG_EN
            TAG: begin
                bus.out_data  = DATA_WIDTH'(r_grant_id) + DATA_WIDTH'(TAG_OFFSET);
                bus.out_valid = 1'b1;
            end
`endif
            STREAM: begin
                bus.out_data        = w_src_data[r_grant_id];
                bus.out_valid       = bus.in_valid[r_grant_id];
                bus.out_last        = bus.in_last[r_grant_id];
                w_ready[r_grant_id] = bus.out_ready;
            end
            default: ;
        endcase
    end

    assign bus.in_ready = w_ready;
    assign grant_id     = r_grant_id;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_packet_stream_arbiter.sv
// Bench for packet_stream_arbiter: packet-ownership model checked every cycle plus directed packet scenarios.
// Works in both builds (PACKET_STREAM_ARBITER_TAG_EN defined or not).
module tb_packet_stream_arbiter;

    localparam int NS = 4;
    localparam int IW = 2;
`ifdef PACKET_STREAM_ARBITER_TAG_EN
    localparam int TAG = 1;
`else
    localparam int TAG = 0;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  src;
        logic [7:0]  d;
        logic        l;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [IW-1:0] grant_id;
    logic          busy;

    packet_stream_arbiter_if #(.NUM_SOURCES(NS)) bus ();

    packet_stream_arbiter #(.NUM_SOURCES(NS)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Source drivers: each source presents the head of its byte queue ({last, data}).
    bit [8:0] srcq [NS][$];
    bit       hold [NS];
    bit       beat [NS];
    ent_t     log_q[$];
    ent_t     exp_q[$];

    task automatic refresh();
        logic [NS*8-1:0] dv;
        dv = '0;
        for (int s = 0; s < NS; s++) begin
            logic [8:0] h;
            h = '0;
            if (srcq[s].size() > 0) h = srcq[s][0];
            bus.in_valid[IW'(s)] = (srcq[s].size() > 0) && !hold[s];
            bus.in_last[IW'(s)]  = h[8];
            dv = dv | ((NS*8)'(h[7:0]) << (8*s));
        end
        bus.in_data = dv;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            for (int s = 0; s < NS; s++) begin
                if (beat[s] && srcq[s].size() > 0) void'(srcq[s].pop_front());
                beat[s] = 1'b0;
            end
            refresh();
        end
    endtask

    task automatic push(input int s, input int d, input bit l);
        srcq[s].push_back({l, 8'(d)});
    endtask

    task automatic flush();
        for (int s = 0; s < NS; s++) begin
            srcq[s].delete();
            hold[s] = 1'b0;
            beat[s] = 1'b0;
        end
        log_q.delete();
        exp_q.delete();
        refresh();
    endtask

    task automatic exp_byte(input int s, input int d, input bit l);
        ent_t e;
        e.cyc = '0; e.src = 8'(s); e.d = 8'(d); e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic exp_tag(input int s);
        if (TAG != 0) exp_byte(s, s + 1, 1'b0);
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int b;
        b = 0;
        while (log_q.size() < n && b < budget) begin
            step(1);
            b++;
        end
        chk({name, " beats arrived"}, int'(log_q.size() >= n), 1);
    endtask

    task automatic cmp_log(input string name);
        chk({name, " beat count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk($sformatf("%s beat%0d data", name, i), int'(log_q[i].d),   int'(exp_q[i].d));
            chk($sformatf("%s beat%0d last", name, i), int'(log_q[i].l),   int'(exp_q[i].l));
            chk($sformatf("%s beat%0d src",  name, i), int'(log_q[i].src), int'(exp_q[i].src));
        end
    endtask

    // Ownership model: who holds the link (-1 = nobody), whether a tag is still owed,
    // and who finished last. Rotation is plain modular search over requesters.
    int   m_owner   = -1;
    int   m_prev    = NS - 1;
    int   m_grant   = 0;
    bit   m_tag_due = 1'b0;
    bit   m_known   = 1'b0;
    int   cyc       = 0;

    always @(negedge clock) begin : compare
        int            e_valid, e_data, e_last, e_busy;
        logic [NS-1:0] e_rdy;
        bit            found;
        int            s;
        ent_t          e;
        cyc++;
        if (m_known) begin
            e_rdy = '0;
            if (m_owner < 0) begin
                e_valid = 0; e_data = 0; e_last = 0; e_busy = 0;
            end else if (m_tag_due) begin
                e_valid = 1; e_data = m_owner + 1; e_last = 0; e_busy = 1;
            end else begin
                e_valid = int'(bus.in_valid[IW'(m_owner)]);
                e_data  = int'(8'(bus.in_data >> (8*m_owner)));
                e_last  = int'(bus.in_last[IW'(m_owner)]);
                e_busy  = 1;
                if (bus.out_ready) e_rdy[IW'(m_owner)] = 1'b1;
            end
            chk("cyc out_valid", int'(bus.out_valid), e_valid);
            if (e_valid != 0) begin
                chk("cyc out_data", int'(bus.out_data), e_data);
                chk("cyc out_last", int'(bus.out_last), e_last);
            end
            chk("cyc in_ready", int'(bus.in_ready), int'(e_rdy));
            chk("cyc busy", int'(busy), e_busy);
            chk("cyc grant_id", int'(grant_id), m_grant);
        end
        for (int k = 0; k < NS; k++) beat[k] = bus.in_valid[IW'(k)] & bus.in_ready[IW'(k)];
        if (bus.out_valid && bus.out_ready) begin
            e.cyc = 32'(cyc); e.src = 8'(grant_id); e.d = bus.out_data; e.l = bus.out_last;
            log_q.push_back(e);
        end
        if (reset) begin
            m_known = 1'b1; m_owner = -1; m_prev = NS - 1; m_grant = 0; m_tag_due = 1'b0;
        end else if (m_known) begin
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k <= NS; k++) begin
                    s = (m_prev + k) % NS;
                    if (!found && bus.in_valid[IW'(s)]) begin
                        found = 1'b1; m_owner = s; m_grant = s; m_tag_due = (TAG != 0);
                    end
                end
            end else if (m_tag_due) begin
                if (bus.out_ready) m_tag_due = 1'b0;
            end else if (bus.in_valid[IW'(m_owner)] && bus.in_last[IW'(m_owner)] && bus.out_ready) begin
                m_prev = m_owner; m_owner = -1;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        flush();
        step(2);
        reset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " busy"},      int'(busy), 0);
        chk({name, " grant_id"},  int'(grant_id), 0);
        chk({name, " out_valid"}, int'(bus.out_valid), 0);
        chk({name, " out_last"},  int'(bus.out_last), 0);
        chk({name, " out_data"},  int'(bus.out_data), 0);
        chk({name, " in_ready"},  int'(bus.in_ready), 0);
    endtask

    initial begin
        int n0, nlast, base;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        flush();
        step(3);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Single source, three bytes back to back.
        push(2, 'hAA, 0); push(2, 'hBB, 0); push(2, 'hCC, 1); refresh();
        exp_tag(2); exp_byte(2, 'hAA, 0); exp_byte(2, 'hBB, 0); exp_byte(2, 'hCC, 1);
        wait_log(3 + TAG, 30, "t1");
        chk("t1 busy after last", int'(busy), 0);
        chk("t1 grant_id", int'(grant_id), 2);
        cmp_log("t1");
        if (log_q.size() >= 3 + TAG)
            chk("t1 bytes contiguous", int'(log_q[TAG+2].cyc - log_q[TAG].cyc), 2);

        // Contention between sources 0 and 1.
        flush();
        push(0, 'h10, 0); push(0, 'h11, 1); push(1, 'h20, 0); push(1, 'h21, 1); refresh();
        exp_tag(0); exp_byte(0, 'h10, 0); exp_byte(0, 'h11, 1);
        exp_tag(1); exp_byte(1, 'h20, 0); exp_byte(1, 'h21, 1);
        wait_log(4 + 2*TAG, 40, "t2");
        cmp_log("t2");
        if (log_q.size() >= 4 + 2*TAG)
            chk("t2 gap between packets", int'(log_q[2*TAG+2].cyc - log_q[TAG+1].cyc), 2 + TAG);

        // Fairness from reset: all sources request single-byte packets.
        do_reset();
        push(0, 'h01, 1); push(0, 'h02, 1);
        push(1, 'h11, 1); push(2, 'h21, 1); push(3, 'h31, 1); refresh();
        exp_tag(0); exp_byte(0, 'h01, 1); exp_tag(1); exp_byte(1, 'h11, 1);
        exp_tag(2); exp_byte(2, 'h21, 1); exp_tag(3); exp_byte(3, 'h31, 1);
        exp_tag(0); exp_byte(0, 'h02, 1);
        wait_log(5*(1+TAG), 80, "t3");
        cmp_log("t3");
        if (log_q.size() >= 5*(1+TAG))
            for (int p = 0; p < 4; p++)
                chk($sformatf("t3 period%0d", p),
                    int'(log_q[(p+1)*(1+TAG)+TAG].cyc - log_q[p*(1+TAG)+TAG].cyc), 2 + TAG);

        // Backpressure and source stall mid-packet, with a competitor waiting.
        flush();
        push(1, 'h31, 0); push(1, 'h32, 0); push(1, 'h33, 0); push(1, 'h34, 1);
        push(2, 'h41, 1); refresh();
        exp_tag(1); exp_byte(1, 'h31, 0); exp_byte(1, 'h32, 0); exp_byte(1, 'h33, 0); exp_byte(1, 'h34, 1);
        exp_tag(2); exp_byte(2, 'h41, 1);
        wait_log(1 + TAG, 20, "t4 first byte");
        n0 = log_q.size();
        bus.out_ready = 1'b0;
        step(5);
        chk("t4 stall no beats", log_q.size(), n0);
        chk("t4 stall grant held", int'(grant_id), 1);
        chk("t4 stall busy", int'(busy), 1);
        chk("t4 stall in_ready", int'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        hold[1] = 1'b1;
        refresh();
        step(3);
        chk("t4 hold no beats", log_q.size(), n0);
        chk("t4 hold grant held", int'(grant_id), 1);
        chk("t4 hold in_ready", int'(bus.in_ready), 'b0010);
        hold[1] = 1'b0;
        refresh();
        wait_log(5 + 2*TAG, 60, "t4");
        cmp_log("t4");

        // Reset in the middle of a four-byte packet.
        do_reset();
        push(3, 'h51, 0); push(3, 'h52, 0); push(3, 'h53, 0); push(3, 'h54, 1); refresh();
        wait_log(2 + TAG, 20, "t5 partial");
        reset = 1'b1;
        step(1);
        chk_reset_outputs("t5 after reset");
        nlast = 0;
        foreach (log_q[i]) if (log_q[i].l) nlast++;
        chk("t5 no out_last seen", nlast, 0);
        flush();
        reset = 1'b0;
        push(3, 'h71, 1); push(0, 'h81, 1); refresh();
        exp_tag(0); exp_byte(0, 'h81, 1); exp_tag(3); exp_byte(3, 'h71, 1);
        wait_log(2 + 2*TAG, 30, "t5");
        cmp_log("t5");

        // Two-byte packet from source 3; carries tag 04 in the tagged build.
        flush();
        push(3, 'h11, 0); push(3, 'h22, 1); refresh();
        exp_tag(3); exp_byte(3, 'h11, 0); exp_byte(3, 'h22, 1);
        base = log_q.size();
        wait_log(base + 2 + TAG, 30, "t6");
        cmp_log("t6");
`ifdef PACKET_STREAM_ARBITER_TAG_EN
        if (log_q.size() > 0) chk("t6 tag byte", int'(log_q[0].d), 'h04);
`endif
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
